// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial adder controller.
`timescale 1ns/1ps
package nibble_serial_add_ctrl_pkg;

    // Controller states; encodings are fixed so debug dumps stay readable.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Width of the shared adder slice.
    localparam int NIBBLE_W = 4;

endpackage

// File: rtl/adder_4bit.sv
// Combinational 4-bit ripple adder slice with carry in/out.
`timescale 1ns/1ps
module adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Full 5-bit add; the top bit is the carry out.
    assign {cout, sum} = {1'b0, A} + {1'b0, B} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice reused over WIDTH/4 cycles,
// least-significant nibble first, with valid/ready on both sides.
`timescale 1ns/1ps
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB) + 1;

    // Reject widths that cannot be split into whole nibbles.
    generate
        if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_reg;
    logic               a_msb;
    logic               b_msb;
    logic [NIBBLE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               load;
    logic               step;
    logic               last;
    logic [WIDTH-1:0]   sum_shift;
    logic               new_ovf;

    adder_4bit u_slice (
        .A    (opa[NIBBLE_W-1:0]),
        .B    (opb[NIBBLE_W-1:0]),
        .cin  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Final nibble step of the current addition.
    assign last = (cnt == CNT_W'(NIB - 1));

    // Partial sum after this step: new slice enters at the top, older nibbles move down.
    // Written as shifts so it also elaborates cleanly for WIDTH == 4.
    assign sum_shift = (sum_reg >> NIBBLE_W) | (WIDTH'(slice_sum) << (WIDTH - NIBBLE_W));

    // Signed overflow: like-signed operands producing a result of the other sign.
    assign new_ovf = (a_msb == b_msb) && (sum_shift[WIDTH-1] != a_msb);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode; acceptance and release never share a cycle.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load       = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                step = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, nibble shifting, inter-nibble carry and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa       <= '0;
            opb       <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
        end else if (load) begin
            opa       <= a;
            opb       <= b;
            carry_reg <= cin;
            a_msb     <= a[WIDTH-1];
            b_msb     <= b[WIDTH-1];
            cnt       <= '0;
        end else if (step) begin
            opa       <= opa >> NIBBLE_W;
            opb       <= opb >> NIBBLE_W;
            sum_reg   <= sum_shift;
            carry_reg <= slice_cout;
            cnt       <= cnt + CNT_W'(1);
        end
    end

    // Result registers update only on entry to DONE, so they hold through IDLE and ADD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (step && last) begin
            sum  <= sum_shift;
            cout <= slice_cout;
            ovf  <= new_ovf;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (WIDTH=16): directed cases
// followed by randomized traffic scored against an arithmetic reference.
`timescale 1ns/1ps
module tb_nibble_serial_add_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    res_t exp_q[$];

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: unsigned sum gives sum/cout, signed sum out of range gives ovf.
    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        res_t r;
        int   u;
        int   s;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        r.sum  = u[WIDTH-1:0];
        r.cout = u[WIDTH];
        r.ovf  = (s > 32767) || (s < -32768);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input res_t e);
        check({tag, "_sum"},  32'(sum),  32'(e.sum));
        check({tag, "_cout"}, 32'(cout), 32'(e.cout));
        check({tag, "_ovf"},  32'(ovf),  32'(e.ovf));
    endtask

    // Offer one operand set; expects the block to be idle, returns just after the accepting edge.
    task automatic send(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Full transaction with out_ready high: latency, busy flag, hold, result, release.
    task automatic run_txn(input string tag, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        res_t             e;
        logic [WIDTH-1:0] prev;
        int               lat;
        e = model(x, y, c);
        prev = sum;
        send(tag, x, y, c);
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        check({tag, "_hold"}, 32'(sum), 32'(prev));
        wait_out(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check_res(tag, e);
        @(posedge clk); #1;
        check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        res_t e;
        int   lat;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed additions.
        run_txn("t1", 16'h0000, 16'hFFFF, 1'b0);
        run_txn("t2", 16'hFFFF, 16'h0001, 1'b0);
        run_txn("t3a", 16'h7FFF, 16'h0001, 1'b0);
        run_txn("t3b", 16'h1234, 16'h4321, 1'b1);
        run_txn("t3c", 16'h8000, 16'h8000, 1'b0);

        // Backpressure: result held, new operands ignored until release.
        out_ready = 1'b0;
        e = model(16'hA5A5, 16'h5A5A, 1'b1);
        send("t4", 16'hA5A5, 16'h5A5A, 1'b1);
        wait_out(lat);
        check("t4_latency", 32'(lat), 32'd4);
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h0101;
        cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_res("t4_held", e);
            check("t4_in_ready_low", 32'(in_ready), 32'd0);
            check("t4_out_valid_high", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_released", 32'(out_valid), 32'd0);
        check("t4_idle_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t4_new_busy", 32'(in_ready), 32'd0);
        wait_out(lat);
        check("t4_new_latency", 32'(lat), 32'd4);
        check_res("t4_new", model(16'h0F0F, 16'h0101, 1'b0));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of ADD.
        send("t5pre", 16'h1111, 16'h2222, 1'b0);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_in_ready", 32'(in_ready), 32'd1);
        check("t5_rst_out_valid", 32'(out_valid), 32'd0);
        check("t5_rst_sum", 32'(sum), 32'd0);
        check("t5_rst_cout", 32'(cout), 32'd0);
        check("t5_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_txn("t5", 16'h00FF, 16'h0001, 1'b0);

        // Randomized traffic with gaps on both handshakes.
        fork
            begin : producer
                for (int i = 0; i < 200; i++) begin
                    int               gap;
                    int               n;
                    logic             rdy;
                    logic             done;
                    logic [WIDTH-1:0] x;
                    logic [WIDTH-1:0] y;
                    logic             c;
                    gap = $urandom_range(0, 3);
                    repeat (gap) begin
                        @(posedge clk); #1;
                    end
                    x = WIDTH'($urandom);
                    y = WIDTH'($urandom);
                    c = 1'($urandom);
                    in_valid = 1'b1;
                    a = x;
                    b = y;
                    cin = c;
                    n = 0;
                    done = 1'b0;
                    while (!done && n < 100) begin
                        rdy = in_ready;
                        @(posedge clk); #1;
                        n++;
                        if (rdy) done = 1'b1;
                    end
                    in_valid = 1'b0;
                    if (!done) begin
                        check("rnd_accept_timeout", 32'd0, 32'd1);
                        break;
                    end
                    exp_q.push_back(model(x, y, c));
                end
            end
            begin : consumer
                int   got;
                int   cyc;
                res_t r;
                got = 0;
                cyc = 0;
                while (got < 200 && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (out_valid && out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rnd_unexpected", 32'd1, 32'd0);
                        end else begin
                            r = exp_q.pop_front();
                            check_res("rnd", r);
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                check("rnd_count", 32'(got), 32'd200);
            end
        join
        check("rnd_leftover", 32'(exp_q.size()), 32'd0);
        out_ready = 1'b1;
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
